// File: rtl/fpaddsub_if.sv
// fpaddsub_if: operand/result stream bundle for fpaddsub_pipe.
// The master drives operands and result backpressure; the slave is the adder.
interface fpaddsub_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic [3:0]   flags;
    modport master (output in_valid, a, b, op, out_ready, input in_ready, out_valid, s, flags);
    modport slave  (input in_valid, a, b, op, out_ready, output in_ready, out_valid, s, flags);
endinterface

// File: rtl/fpaddsub_pipe.sv
// fpaddsub_pipe: three-stage IEEE-754 adder/subtractor, round-to-nearest-even, denormals flushed.
// Stages: unpack/align, magnitude add, normalise/round; the whole pipe stalls as one unit.
module fpaddsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic       clk,
    input logic       reset,
    fpaddsub_if.slave io
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int M    = MAN_W + 1;
    localparam int AW   = MAN_W + 4;
    localparam int SW   = MAN_W + 5;
    localparam int LZW  = $clog2(SW);
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             sign;
        logic             sub;
        logic [EXP_W-1:0] exp;
        logic [M-1:0]     ml;
        logic [AW-1:0]    ms;
        logic             spec;
        logic             spec_inv;
        logic [W-1:0]     spec_res;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic             zsign;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    sum;
        logic             spec;
        logic             spec_inv;
        logic [W-1:0]     spec_res;
    } s2_t;

    logic         adv;
    logic         v1_q, v2_q, ov_q;
    s1_t          s1_q, s1_d;
    s2_t          s2_q, s2_d;
    logic [W-1:0] s_q, s_d;
    logic [3:0]   f_q, f_d;

    assign adv          = !ov_q || io.out_ready;
    assign io.in_ready  = adv;
    assign io.out_valid = ov_q;
    assign io.s         = s_q;
    assign io.flags     = f_q;

    logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, b_gt, inf_sub;
    logic [EXP_W-1:0] ea, eb, diff;
    logic [M-1:0]     ma, mb, msm;
    logic [AW-1:0]    ms_ext, shifted;

    always_comb begin
        sa      = io.a[W-1];
        sb      = io.b[W-1] ^ io.op;
        ea      = io.a[W-2:MAN_W];
        eb      = io.b[W-2:MAN_W];
        a_zero  = ea == '0;
        b_zero  = eb == '0;
        a_inf   = &ea && io.a[MAN_W-1:0] == '0;
        b_inf   = &eb && io.b[MAN_W-1:0] == '0;
        a_nan   = &ea && io.a[MAN_W-1:0] != '0;
        b_nan   = &eb && io.b[MAN_W-1:0] != '0;
        inf_sub = a_inf && b_inf && sa != sb;
        ma      = a_zero ? '0 : {1'b1, io.a[MAN_W-1:0]};
        mb      = b_zero ? '0 : {1'b1, io.b[MAN_W-1:0]};
        b_gt    = {eb, mb} > {ea, ma};
        msm     = b_gt ? ma : mb;
        diff    = b_gt ? eb - ea : ea - eb;
        ms_ext  = {msm, 3'b000};
        shifted = ms_ext >> diff;
        s1_d.sign     = b_gt ? sb : sa;
        s1_d.sub      = sa ^ sb;
        s1_d.exp      = b_gt ? eb : ea;
        s1_d.ml       = b_gt ? mb : ma;
        s1_d.ms       = (int'(diff) >= MAN_W + 3) ? {{(AW-1){1'b0}}, |msm}
                      : {shifted[AW-1:1], shifted[0] | |(ms_ext & ~({AW{1'b1}} << diff))};
        s1_d.spec     = a_nan || b_nan || a_inf || b_inf;
        s1_d.spec_inv = (a_nan && !io.a[MAN_W-1]) || (b_nan && !io.b[MAN_W-1]) || inf_sub;
        s1_d.spec_res = (a_nan || b_nan || inf_sub) ? QNAN
                      : {a_inf ? sa : sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    // Larger magnitude is always first, so the difference cannot go negative.
    always_comb begin
        s2_d.sign     = s1_q.sign;
        s2_d.zsign    = s1_q.sign && !s1_q.sub;
        s2_d.exp      = s1_q.exp;
        s2_d.sum      = s1_q.sub ? {1'b0, s1_q.ml, 3'b000} - {1'b0, s1_q.ms}
                                 : {1'b0, s1_q.ml, 3'b000} + {1'b0, s1_q.ms};
        s2_d.spec     = s1_q.spec;
        s2_d.spec_inv = s1_q.spec_inv;
        s2_d.spec_res = s1_q.spec_res;
    end

    logic [LZW-1:0] lz;
    logic [AW-1:0]  norm;
    logic [M:0]     mant_r;
    logic           rup;
    int             e_n, e_r;

    always_comb begin
        lz = '0;
        for (int i = 0; i < SW - 1; i++)
            if (s2_q.sum[i]) lz = LZW'(SW - 2 - i);
        norm   = s2_q.sum[SW-1] ? {s2_q.sum[SW-1:2], |s2_q.sum[1:0]} : s2_q.sum[SW-2:0] << lz;
        e_n    = s2_q.sum[SW-1] ? int'(s2_q.exp) + 1 : int'(s2_q.exp) - int'(lz);
        rup    = norm[2] && (norm[1] || norm[0] || norm[3]);
        mant_r = {1'b0, norm[AW-1:3]} + {{M{1'b0}}, rup};
        e_r    = e_n + int'(mant_r[M]);
        s_d    = s2_q.spec ? s2_q.spec_res
               : s2_q.sum == '0 ? {s2_q.zsign, {(W-1){1'b0}}}
               : e_r >= EMAX ? {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
               : e_r <= 0 ? {s2_q.sign, {(W-1){1'b0}}}
               : {s2_q.sign, e_r[EXP_W-1:0], mant_r[M] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0]};
        f_d    = s2_q.spec ? {s2_q.spec_inv, 3'b000}
               : s2_q.sum == '0 ? 4'b0000
               : e_r >= EMAX ? 4'b0101
               : e_r <= 0 ? 4'b0011
               : {3'b000, |norm[2:0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            ov_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s_q  <= '0;
            f_q  <= '0;
        end else if (adv) begin
            v1_q <= io.in_valid;
            v2_q <= v1_q;
            ov_q <= v2_q;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s_q  <= s_d;
            f_q  <= f_d;
        end
    end
endmodule

// File: tb/tb_fpaddsub_pipe.sv
// tb_fpaddsub_pipe: directed FP32 vectors with a scoreboard queue and an independent result monitor.
module tb_fpaddsub_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fpaddsub_if #(.EXP_W(8), .MAN_W(23)) io ();
    fpaddsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .reset(reset), .io(io));

    typedef struct packed {
        logic [31:0] s;
        logic [3:0]  f;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] s;
        logic [3:0]  f;
    } vec_t;

    vec_t tbl [15] = '{
        '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000},
        '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000},
        '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001},
        '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001},
        '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000},
        '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101},
        '{32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000},
        '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000},
        '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011},
        '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000},
        '{32'h3F7FFFFF, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000},
        '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001},
        '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000},
        '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000}
    };

    vec_t bp [5] = '{
        '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000},
        '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000},
        '{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000},
        '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000},
        '{32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 4'b0000}
    };

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic issue(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        io.in_valid = 1'b1;
        io.a        = v.a;
        io.b        = v.b;
        io.op       = v.op;
        while (!io.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!io.in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stuck at 0");
            io.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        q.push_back('{s: v.s, f: v.f});
        #1 io.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(q.size()), 32'd0);
    endtask

    task automatic latency(input vec_t v);
        issue(v);
        @(negedge clk);
        check("lat_c1_valid", 32'(io.out_valid), 32'd0);
        @(negedge clk);
        check("lat_c2_valid", 32'(io.out_valid), 32'd0);
        @(negedge clk);
        check("lat_c3_valid", 32'(io.out_valid), 32'd1);
        check("lat_c3_s", io.s, v.s);
    endtask

    always @(negedge clk) begin
        if (reset && io.out_valid && io.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got s=%h flags=%b with no pending op", io.s, io.flags);
            end else begin
                mon_e = q.pop_front();
                check("result_s", io.s, mon_e.s);
                check("result_flags", 32'(io.flags), 32'(mon_e.f));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        io.in_valid  = 1'b0;
        io.a         = '0;
        io.b         = '0;
        io.op        = 1'b0;
        io.out_ready = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(io.out_valid), 32'd0);
        check("rst_s", io.s, 32'd0);
        check("rst_flags", 32'(io.flags), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(io.in_ready), 32'd1);

        latency('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000});
        drain();

        for (int i = 0; i < 15; i++) issue(tbl[i]);
        drain();

        @(posedge clk);
        #1 io.out_ready = 1'b0;
        fork
            for (int i = 0; i < 5; i++) issue(bp[i]);
            begin
                n = 0;
                while (!io.out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_fill_valid", 32'(io.out_valid), 32'd1);
                for (int k = 0; k < 4; k++) begin
                    check("bp_hold_s", io.s, 32'h40000000);
                    check("bp_in_ready_low", 32'(io.in_ready), 32'd0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 io.out_ready = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_consecutive_valid", 32'(io.out_valid), 32'd1);
                end
            end
        join
        drain();

        for (int i = 0; i < 3; i++) issue(bp[i]);
        #1 reset = 1'b0;
        q.delete();
        #1;
        check("midrst_out_valid", 32'(io.out_valid), 32'd0);
        check("midrst_s", io.s, 32'd0);
        check("midrst_flags", 32'(io.flags), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("no_stale_valid", 32'(io.out_valid), 32'd0);
        end
        latency('{32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000});
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpaddsub_pipe.md
# fpaddsub_pipe

Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor with a valid/ready stream interface. It is the successor to the team's single-cycle combinational float adder. It adds:
- configurable exponent and mantissa widths
- an add/subtract mode
- round-to-nearest-even
- special-value handling and exception flags
- a three-stage pipeline with backpressure

It sits in the ALU datapath behind the operand register file and feeds the result writeback stage.

## Interface
- EXP_W, default 8: exponent field width, minimum 4.
- MAN_W, default 23: stored mantissa (fraction) width, minimum 4. Word width is W = 1 + EXP_W + MAN_W.
- clk, input, 1: the block's only clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operands a, b and op are valid this cycle.
- in_ready, output, 1: the block accepts operands this cycle.
- a, input, W: first operand, packed as sign, exponent, fraction.
- b, input, W: second operand, packed as sign, exponent, fraction.
- op, input, 1: 0 computes a+b; 1 computes a−b (sign of b inverted).
- out_valid, output, 1: s and flags are valid.
- out_ready, input, 1: the consumer accepts the result this cycle.
- s, output, W: the result.
- flags, output, 4: {invalid, overflow, underflow, inexact}.

## Operation
- An operand transfer occurs when in_valid && in_ready. A result transfer occurs when out_valid && out_ready.
- **Stage 1, unpack and align:**
  - Classify each operand as zero, normal, inf or NaN. Denormal inputs (exp==0, frac!=0) are flushed to signed zero.
  - Prepend the hidden one to normal operands.
  - Swap the operands so the larger magnitude is first (compare exponent, then fraction).
  - Right-shift the smaller mantissa by the exponent difference into a datapath of MAN_W+1 mantissa bits plus guard, round and sticky bits. Sticky is the OR of all bits shifted out.
  - A shift of MAN_W+3 or more yields zero mantissa with sticky set if the smaller operand was nonzero.
- **Stage 2, add:**
  - Effective subtract = sign_a XOR sign_b (after op).
  - Add or subtract the magnitudes in a MAN_W+5 bit unsigned datapath. The large-minus-small order means the result is never negative.
  - The result sign is the sign of the larger operand.
- **Stage 3, normalise and round:**
  - On carry-out: shift right by 1 (sticky absorbs the lost bit) and increment the exponent.
  - Otherwise: shift left by the leading-zero count and subtract it from the exponent.
  - Round to nearest, ties to even, using guard/round/sticky. A mantissa overflow from rounding re-normalises and increments the exponent.
- **Results:**
  - Exponent ≥ all-ones: ±inf, overflow=1, inexact=1.
  - Exponent ≤ 0 for a nonzero result: flushed to signed zero, underflow=1, inexact=1.
  - Exact cancellation gives +0. Only (−0)+(−0) gives −0.
- **Specials, highest priority first:**
  - Either input NaN, or inf−inf (effective subtract of equal-sign-adjusted infinities): canonical quiet NaN (sign 0, exp all ones, fraction MSB 1, rest 0).
    - invalid=1 for inf−inf and for signalling NaN inputs (fraction MSB 0).
  - Exactly one input inf, or both inf with effective add: that inf, no flags.
- inexact=1 whenever guard, round or sticky was nonzero before rounding, or whenever overflow or underflow is set.

## Timing
- Latency: exactly 3 cycles from operand transfer to out_valid when out_ready stays high. Throughput is one operation per cycle.
- Pipeline advance = !out_valid || out_ready. The whole pipeline stalls as one unit; in_ready equals advance (combinational from out_ready). There are no bubbles inserted while advancing.
- While stalled, s, flags and out_valid hold stable and all stage registers hold.
- Results leave in acceptance order, with no loss or duplication.
- Reset (reset=0, any time, including mid-operation):
  - All stage valid bits clear immediately; out_valid=0, s=0, flags=0.
  - In-flight operations are discarded.
  - in_ready=1 from the first cycle after reset deasserts.
- in_valid asserted while in_ready=0 is ignored. The source must hold its operands until the transfer occurs.

## Test plan
Test plan values use the defaults (FP32).
- **Basic add:** a=0x3F800000, b=0x40000000, op=0 accepted at cycle 0, out_ready=1 → s=0x40400000, flags=0000, out_valid exactly at cycle 3.
- **Cancellation:** a=0x3F800000, b=0x3F800000, op=1 → s=0x00000000. Then a=0x80000000, b=0x00000000, op=1 → s=0x80000000.
- **Rounding ties:**
  - 0x3F800000 + 0x33800000 → 0x3F800000, inexact=1.
  - 0x3F800001 + 0x33800000 → 0x3F800002, inexact=1.
- **Specials and overflow:**
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1.
  - 0x7FC00000 + 0x3F800000 → 0x7FC00000, invalid=0.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
- **Backpressure:** issue 5 back-to-back ops and hold out_ready=0 for 4 cycles.
  - in_ready drops once the pipeline is full.
  - s holds the first result throughout the stall.
  - After release, all 5 results emerge in order on consecutive cycles.
- **Reset mid-flight:** pulse reset=0 for 1 cycle with 3 ops in flight → out_valid=0, s=0, flags=0 immediately. No stale result appears afterward; the next op completes with 3-cycle latency.
